serial_capture_unit: RTL

- Bit-serial receiver, the capture end of the lab-4 shift datapath.
- Samples the serial bit stream that the register unit shifts out under Shift_En, LSB first, and assembles WIDTH-bit words.
- Presents each completed word on a stable parallel output with a valid/ack handshake, so the top level can show results on the HEX digits and LEDs.
- Flags bits lost while a completed word is still unacknowledged.

---
 rtl/serial_capture_unit_pkg.sv | 16 +
 rtl/serial_capture_unit_sipo_shift_reg.sv | 38 +++
 rtl/serial_capture_unit.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/serial_capture_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_capture_unit_pkg
// Brief    : Shared types for the bit-serial capture unit.
// Revision : 1.0 - initial release
// ============================================================================
package serial_capture_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_capture_unit_sipo_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : sipo_shift_reg
// Brief    : Serial-in parallel-out register, right shift with data entering at
//            the MSB; clear and shift together load {bit, zeros}.
// Revision : 1.0 - initial release
// ============================================================================
module sipo_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_clr,
    input  logic             i_shift,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-2:0] w_lower;

    // Clearing while shifting starts a fresh word with no stale bits below.
    assign w_lower = i_clr ? '0 : r_q[WIDTH-1:1];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_q <= '0;
        end else if (i_shift) begin
            r_q <= {i_bit, w_lower};
        end else if (i_clr) begin
            r_q <= '0;
        end
    end

    assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/serial_capture_unit.sv
`default_nettype none
// ============================================================================
// Module   : serial_capture_unit
// Brief    : LSB-first bit-serial receiver that assembles WIDTH-bit words and
//            holds each one behind a valid/ack handshake with overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module serial_capture_unit
    import serial_capture_unit_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Shift_En,
    input  logic             Bit_In,
    input  logic             Data_Ack,
    output logic [WIDTH-1:0] Data_Out,
    output logic             Data_Valid,
    output logic             Busy,
    output logic             Overrun,
    output logic [CW-1:0]    Bit_Count
);

    localparam logic [CW-1:0] c_CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [CW-1:0]    w_count_inc;
    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] w_data_out_nxt;
    logic             r_overrun;
    logic             w_overrun_nxt;
    logic             w_sr_clr;
    logic             w_sr_shift;
    logic [WIDTH-1:0] w_sr_q;
    logic [WIDTH-1:0] w_sr_shifted;
    logic             w_sr_lsb_unused;

    sipo_shift_reg #(
        .WIDTH (WIDTH)
    ) u_sipo (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_clr   (w_sr_clr),
        .i_shift (w_sr_shift),
        .i_bit   (Bit_In),
        .o_q     (w_sr_q)
    );

    // The completing bit is captured into Data_Out on the same edge it is
    // shifted in, so the word is taken from the shift register's next value.
    assign w_sr_shifted    = {Bit_In, w_sr_q[WIDTH-1:1]};
    assign w_sr_lsb_unused = w_sr_q[0];
    assign w_count_inc     = r_count + c_CNT_ONE;

    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_data_out_nxt = r_data_out;
        w_overrun_nxt  = r_overrun;
        w_sr_clr       = 1'b0;
        w_sr_shift     = 1'b0;

        if (Clear) begin
            w_state_nxt    = ST_IDLE;
            w_count_nxt    = '0;
            w_data_out_nxt = '0;
            w_overrun_nxt  = 1'b0;
            w_sr_clr       = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Shift_En) begin
                        w_sr_clr    = 1'b1;
                        w_sr_shift  = 1'b1;
                        w_count_nxt = c_CNT_ONE;
                        w_state_nxt = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (Shift_En) begin
                        w_sr_shift  = 1'b1;
                        w_count_nxt = w_count_inc;
                        if (w_count_inc == c_CNT_FULL) begin
                            w_state_nxt    = ST_HOLD;
                            w_data_out_nxt = w_sr_shifted;
                        end
                    end
                end
                ST_HOLD: begin
                    if (Data_Ack) begin
                        if (Shift_En) begin
                            w_sr_clr    = 1'b1;
                            w_sr_shift  = 1'b1;
                            w_count_nxt = c_CNT_ONE;
                            w_state_nxt = ST_SHIFT;
                        end else begin
                            w_count_nxt = '0;
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (Shift_En) begin
                        w_overrun_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_data_out <= '0;
            r_overrun  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_count    <= w_count_nxt;
            r_data_out <= w_data_out_nxt;
            r_overrun  <= w_overrun_nxt;
        end
    end

    assign Data_Out   = r_data_out;
    assign Data_Valid = (r_state == ST_HOLD);
    assign Busy       = (r_state == ST_SHIFT);
    assign Overrun    = r_overrun;
    assign Bit_Count  = r_count;

endmodule
`default_nettype wire
